fx2_ep_model: RTL

Parametrised FX2 slave-FIFO endpoint model: one endpoint of configurable direction, data width, packet size and buffer count, with packet-granular buffering, auto-commit at full packet size, short and zero-length packets via PKTEND, and FULL/EMPTY/programmable flags. The FX2 test fixture instantiates one per endpoint (EP2/4/6/8), sharing `fd`, `fifoadr` and strobes. The FPGA-facing side matches slave-FIFO pin semantics. The host-facing side lets benches stage OUT packets and drain IN packets.

---
 rtl/fx2_pkg.sv | 20 ++
 rtl/fx2_pkt_ring.sv | 129 ++++++++++++
 rtl/fx2_ep_model.sv | 135 +++++++++++++
 3 files changed

// File: rtl/fx2_pkg.sv
// fx2_pkg
// Shared constants for the FX2 slave-FIFO endpoint model.
//   DIR_OUT / DIR_IN       : endpoint direction codes (OUT = host->FPGA)
//   FIFOADR_EP2..EP8       : slave-FIFO address codes of the four endpoints
//   len_width()            : bits needed to hold a packet length 0..words
package fx2_pkg;

    localparam int DIR_OUT = 0;
    localparam int DIR_IN  = 1;

    localparam logic [1:0] FIFOADR_EP2 = 2'b00;
    localparam logic [1:0] FIFOADR_EP4 = 2'b01;
    localparam logic [1:0] FIFOADR_EP6 = 2'b10;
    localparam logic [1:0] FIFOADR_EP8 = 2'b11;

    function automatic int len_width(input int words);
        return $clog2(words + 1);
    endfunction

endpackage

// File: rtl/fx2_pkt_ring.sv
// fx2_pkt_ring
// Packet-granular ring of NBUF buffers, each PKT_SIZE words deep.
// Ports:
//   ifclk, reset_n     : clock, asynchronous active-low reset
//   p_wr, p_commit     : producer write / end-of-packet strobes
//   p_data             : producer data word
//   c_rd               : consumer read strobe
//   rd_data            : word at the head buffer's read pointer (0 when empty)
//   count              : number of committed buffers, 0..NBUF
//   wr_ptr, rd_ptr     : fill level of the staging buffer / drain position
//   head_len           : length of the head (oldest committed) packet
//   release_pkt        : high in the cycle whose edge releases the head buffer
module fx2_pkt_ring
    import fx2_pkg::*;
#(
    parameter int DIR      = DIR_IN,
    parameter int DATA_W   = 8,
    parameter int PKT_SIZE = 512,
    parameter int NBUF     = 4,
    localparam int LEN_W   = len_width(PKT_SIZE),
    localparam int CNT_W   = $clog2(NBUF + 1)
) (
    input  logic              ifclk,
    input  logic              reset_n,
    input  logic              p_wr,
    input  logic              p_commit,
    input  logic [DATA_W-1:0] p_data,
    input  logic              c_rd,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count,
    output logic [LEN_W-1:0]  wr_ptr,
    output logic [LEN_W-1:0]  rd_ptr,
    output logic [LEN_W-1:0]  head_len,
    output logic              release_pkt
);

    localparam int BUF_W = (NBUF > 2) ? 2 : 1;
    localparam int DEPTH = NBUF * PKT_SIZE;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // OUT endpoints have no host-side reader to consume a zero-length
    // packet, so such a head packet drops out on its own.
    localparam bit AUTO_ZLP = (DIR == DIR_OUT);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [LEN_W-1:0]  len [NBUF];
    logic [BUF_W-1:0]  wr_buf;
    logic [BUF_W-1:0]  rd_buf;
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     rd_addr;
    logic [LEN_W-1:0]  wr_ptr_inc;
    logic [LEN_W-1:0]  rd_ptr_inc;
    logic              has_room;
    logic              wr_ok;
    logic              commit_ok;
    logic              rd_ok;

    function automatic logic [BUF_W-1:0] buf_next(input logic [BUF_W-1:0] b);
        return (b == BUF_W'(NBUF - 1)) ? '0 : b + BUF_W'(1);
    endfunction

    assign has_room   = (count != CNT_W'(NBUF));
    assign wr_ok      = p_wr & has_room;
    assign wr_ptr_inc = wr_ptr + LEN_W'(1);
    // An explicit commit and an auto-commit landing together collapse into
    // one commit because both just feed this single enable.
    assign commit_ok  = has_room & (p_commit | (p_wr & (wr_ptr_inc == LEN_W'(PKT_SIZE))));

    assign head_len   = len[rd_buf];
    assign rd_ptr_inc = rd_ptr + LEN_W'(1);
    assign rd_ok      = c_rd & (count != '0) & (head_len != '0);

    assign wr_addr = AW'(int'(wr_buf) * PKT_SIZE + int'(wr_ptr));
    assign rd_addr = AW'(int'(rd_buf) * PKT_SIZE + int'(rd_ptr));
    assign rd_data = (count == '0) ? '0 : mem[rd_addr];

    always_comb begin
        release_pkt = 1'b0;
        if (count != '0) begin
            if (head_len == '0) begin
                release_pkt = AUTO_ZLP | c_rd;
            end else begin
                release_pkt = c_rd & (rd_ptr_inc == head_len);
            end
        end
    end

    // Packet storage is not reset; count == 0 masks whatever it holds.
    always_ff @(posedge ifclk) begin
        if (wr_ok) begin
            mem[wr_addr] <= p_data;
        end
    end

    always_ff @(posedge ifclk or negedge reset_n) begin
        if (!reset_n) begin
            wr_buf <= '0;
            wr_ptr <= '0;
            rd_buf <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < NBUF; i++) begin
                len[i] <= '0;
            end
        end else begin
            if (commit_ok) begin
                // The word written in the commit cycle belongs to the packet.
                len[wr_buf] <= wr_ok ? wr_ptr_inc : wr_ptr;
                wr_buf      <= buf_next(wr_buf);
                wr_ptr      <= '0;
            end else if (wr_ok) begin
                wr_ptr <= wr_ptr_inc;
            end

            if (release_pkt) begin
                rd_buf <= buf_next(rd_buf);
                rd_ptr <= '0;
            end else if (rd_ok) begin
                rd_ptr <= rd_ptr_inc;
            end

            if (commit_ok && !release_pkt) begin
                count <= count + CNT_W'(1);
            end else if (release_pkt && !commit_ok) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fx2_ep_model.sv
// fx2_ep_model
// One FX2 slave-FIFO endpoint: FPGA-facing slave-FIFO pins on one side,
// host-facing stage/drain ports on the other, packet ring in between.
// Ports:
//   ifclk, reset_n                 : clock, asynchronous active-low reset
//   fifoadr                        : endpoint select, matched against FIFOADR
//   slrd, slwr, pktend, sloe       : FPGA strobes (ignored unless selected)
//   fd_in / fd_out, fd_oe          : FPGA write data / read data and its enable
//   flag_empty, flag_full, flag_prog : FPGA-side FIFO flags
//   host_data_in, host_wr, host_commit : host producer (OUT endpoints)
//   host_rd, host_data_out         : host consumer (IN endpoints)
//   host_pkt_avail, host_pkt_len   : head packet present / its length
//   host_pkt_done                  : one-cycle pulse after each release
//   overflow, underflow            : sticky error flags
module fx2_ep_model
    import fx2_pkg::*;
#(
    parameter int         DIR      = DIR_IN,
    parameter int         DATA_W   = 8,
    parameter int         PKT_SIZE = 512,
    parameter int         NBUF     = 4,
    parameter logic [1:0] FIFOADR  = FIFOADR_EP6,
    parameter int         PROG_LVL = 64,
    localparam int        LEN_W    = len_width(PKT_SIZE)
) (
    input  logic              ifclk,
    input  logic              reset_n,
    input  logic [1:0]        fifoadr,
    input  logic              slrd,
    input  logic              slwr,
    input  logic              pktend,
    input  logic              sloe,
    input  logic [DATA_W-1:0] fd_in,
    output logic [DATA_W-1:0] fd_out,
    output logic              fd_oe,
    output logic              flag_empty,
    output logic              flag_full,
    output logic              flag_prog,
    input  logic [DATA_W-1:0] host_data_in,
    input  logic              host_wr,
    input  logic              host_commit,
    input  logic              host_rd,
    output logic [DATA_W-1:0] host_data_out,
    output logic              host_pkt_avail,
    output logic [LEN_W-1:0]  host_pkt_len,
    output logic              host_pkt_done,
    output logic              overflow,
    output logic              underflow
);

    localparam int CNT_W  = $clog2(NBUF + 1);
    localparam bit IS_IN  = (DIR == DIR_IN);

    logic              sel;
    logic              p_wr;
    logic              p_commit;
    logic              c_rd;
    logic [DATA_W-1:0] p_data;
    logic [DATA_W-1:0] rd_data;
    logic [CNT_W-1:0]  count;
    logic [LEN_W-1:0]  wr_ptr;
    logic [LEN_W-1:0]  rd_ptr;
    logic [LEN_W-1:0]  head_len;
    logic              release_pkt;
    logic              ring_empty;
    logic              ring_full;
    int                free_words;
    int                head_left;

    assign sel      = (fifoadr == FIFOADR);
    assign p_wr     = IS_IN ? (slwr & sel)   : host_wr;
    assign p_commit = IS_IN ? (pktend & sel) : host_commit;
    assign p_data   = IS_IN ? fd_in          : host_data_in;
    assign c_rd     = IS_IN ? host_rd        : (slrd & sel);

    fx2_pkt_ring #(
        .DIR      (DIR),
        .DATA_W   (DATA_W),
        .PKT_SIZE (PKT_SIZE),
        .NBUF     (NBUF)
    ) u_ring (
        .ifclk       (ifclk),
        .reset_n     (reset_n),
        .p_wr        (p_wr),
        .p_commit    (p_commit),
        .p_data      (p_data),
        .c_rd        (c_rd),
        .rd_data     (rd_data),
        .count       (count),
        .wr_ptr      (wr_ptr),
        .rd_ptr      (rd_ptr),
        .head_len    (head_len),
        .release_pkt (release_pkt)
    );

    assign ring_empty = (count == '0);
    assign ring_full  = (count == CNT_W'(NBUF));

    assign flag_empty     = ring_empty;
    assign flag_full      = ring_full;
    assign fd_oe          = sloe & sel & ~IS_IN;
    assign fd_out         = IS_IN ? '0 : rd_data;
    assign host_data_out  = IS_IN ? rd_data : '0;
    assign host_pkt_avail = ~ring_empty;
    assign host_pkt_len   = ring_empty ? '0 : head_len;

    // IN: warn when little writable space is left for the FPGA.
    // OUT: warn when the FPGA is about to run out of readable words.
    always_comb begin
        free_words = (NBUF - int'(count)) * PKT_SIZE - int'(wr_ptr);
        head_left  = int'(head_len) - int'(rd_ptr);
        if (IS_IN) begin
            flag_prog = (free_words <= PROG_LVL);
        end else begin
            flag_prog = ring_empty | ((count == CNT_W'(1)) & (head_left <= PROG_LVL));
        end
    end

    always_ff @(posedge ifclk or negedge reset_n) begin
        if (!reset_n) begin
            overflow      <= 1'b0;
            underflow     <= 1'b0;
            host_pkt_done <= 1'b0;
        end else begin
            host_pkt_done <= release_pkt;
            if ((p_wr | p_commit) & ring_full) begin
                overflow <= 1'b1;
            end
            if (c_rd & ring_empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule
